// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sync header, then payload MSB first, then a zero guard gap.
// Latency: a load accepted at edge N shows the first header bit in cycle N+1; one bit per tx_en strobe.
// Backpressure: load_ready is high only in IDLE; tx_en low freezes every output and the FSM.
module seq_pattern_tx #(
    parameter int                 WIDTH = 32,
    parameter int                 LEN_W = $clog2(WIDTH) + 1,
    parameter int                 HDR_W = 2,
    parameter logic [HDR_W-1:0]   HDR   = 2'b11,
    parameter int                 GAP   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      load_data,
    input  logic [LEN_W-1:0]      load_len,
    input  logic                  tx_en,
    output logic                  tx_bit,
    output logic                  tx_valid,
    output logic                  done,
    output logic                  busy
);

    // One counter serves header, payload and gap, so size it for the largest of the three.
    localparam int                CNT_W   = $clog2(WIDTH + HDR_W + GAP + 1);
    localparam logic [LEN_W-1:0]  WIDTH_L = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             r_state,    w_state_n;
    logic [HDR_W-1:0]   r_hdr_sh,   w_hdr_sh_n;
    logic [WIDTH-1:0]   r_pay_sh,   w_pay_sh_n;
    logic [LEN_W-1:0]   r_len,      w_len_n;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_n;
    logic               r_tx_bit,   w_tx_bit_n;
    logic               r_tx_valid, w_tx_valid_n;
    logic               r_done,     w_done_n;
    logic               r_busy;

    logic [LEN_W-1:0]   w_len_clamp;
    logic [LEN_W-1:0]   w_shamt;

    // Clamp the requested length and left-align the payload so its first bit sits at the MSB.
    always_comb begin
        w_len_clamp = (load_len > WIDTH_L) ? WIDTH_L : load_len;
        w_shamt     = WIDTH_L - w_len_clamp;
    end

    // Next-state and next-output logic; shift registers always present the next bit at their MSB.
    always_comb begin
        w_state_n    = r_state;
        w_hdr_sh_n   = r_hdr_sh;
        w_pay_sh_n   = r_pay_sh;
        w_len_n      = r_len;
        w_cnt_n      = r_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_valid_n = r_tx_valid;
        w_done_n     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_state_n    = S_HDR;
                    w_hdr_sh_n   = HDR;
                    w_pay_sh_n   = load_data << w_shamt;
                    w_len_n      = w_len_clamp;
                    w_cnt_n      = CNT_W'(HDR_W - 1);
                    w_tx_bit_n   = HDR[HDR_W-1];
                    w_tx_valid_n = 1'b1;
                end
            end
            S_HDR: begin
                if (tx_en) begin
                    if (r_cnt != '0) begin
                        w_hdr_sh_n = r_hdr_sh << 1;
                        w_tx_bit_n = w_hdr_sh_n[HDR_W-1];
                        w_cnt_n    = r_cnt - CNT_W'(1);
                    end else if (r_len != '0) begin
                        w_state_n  = S_DATA;
                        w_cnt_n    = CNT_W'(r_len - 1'b1);
                        w_tx_bit_n = r_pay_sh[WIDTH-1];
                    end else begin
                        w_state_n    = (GAP > 0) ? S_GAP : S_IDLE;
                        w_cnt_n      = CNT_W'(GAP - 1);
                        w_tx_bit_n   = 1'b0;
                        w_tx_valid_n = 1'b0;
                        w_done_n     = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tx_en) begin
                    if (r_cnt != '0) begin
                        w_pay_sh_n = r_pay_sh << 1;
                        w_tx_bit_n = w_pay_sh_n[WIDTH-1];
                        w_cnt_n    = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_n    = (GAP > 0) ? S_GAP : S_IDLE;
                        w_cnt_n      = CNT_W'(GAP - 1);
                        w_tx_bit_n   = 1'b0;
                        w_tx_valid_n = 1'b0;
                        w_done_n     = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tx_en) begin
                    if (r_cnt != '0) begin
                        w_cnt_n = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_n    = S_IDLE;
                w_tx_bit_n   = 1'b0;
                w_tx_valid_n = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hdr_sh   <= '0;
            r_pay_sh   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_hdr_sh   <= w_hdr_sh_n;
            r_pay_sh   <= w_pay_sh_n;
            r_len      <= w_len_n;
            r_cnt      <= w_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_valid <= w_tx_valid_n;
            r_done     <= w_done_n;
            r_busy     <= (w_state_n != S_IDLE);
        end
    end

    // Output mapping; ready is simply the complement of the registered busy flag.
    always_comb begin
        tx_bit     = r_tx_bit;
        tx_valid   = r_tx_valid;
        done       = r_done;
        busy       = r_busy;
        load_ready = !r_busy;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter; the driving end of the single-bit serial link consumed by the sequence-detector FSM. Accepts a parallel word plus bit count over a valid/ready handshake, then emits a fixed sync header followed by the payload, one bit per `tx_en` strobe, MSB first. Finishes with a zero-filled guard gap so the downstream detector returns to its idle state before the next frame.

## Interface
- `WIDTH`, 32: payload register width.
- `LEN_W`, $clog2(WIDTH)+1: width of `load_len`.
- `HDR_W`, 2: header length in bits; must be ≥1.
- `HDR`, 2'b11: header pattern, sent MSB first.
- `GAP`, 2: guard bits (zeros) after each frame; 0 allowed.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `load_valid` in 1: request to start a frame.
- `load_ready` out 1: block is idle and accepting a frame.
- `load_data` in WIDTH: payload; bits [load_len-1:0] are used.
- `load_len` in LEN_W: payload bit count, 0..WIDTH.
- `tx_en` in 1: bit strobe; the current bit is consumed and the FSM advances only when high.
- `tx_bit` out 1: serial data, registered.
- `tx_valid` out 1: `tx_bit` is a header or payload bit, registered.
- `done` out 1: one-cycle pulse at frame end, registered.
- `busy` out 1: frame or gap in progress, registered.

## Operation
- States: IDLE, HDR, DATA, GAP.
- IDLE: `load_ready`=1. Accept on `load_valid && load_ready` at a rising edge. Latch `load_data`, and latch `load_len` clamped to WIDTH. Go to HDR with `tx_bit`=HDR[HDR_W-1] and `tx_valid`=1.
- HDR: each `tx_en` edge advances the header index. After bit HDR[0] is consumed: go to DATA if len>0; if len=0, end the frame.
- DATA: `tx_bit`=payload[len-1] first, down to payload[0]. Each `tx_en` edge advances one bit. Consuming payload[0] ends the frame.
- Frame end (same edge): `tx_valid`→0, `tx_bit`→0, `done`=1 for exactly one cycle. Go to GAP if GAP>0, else IDLE.
- GAP: `tx_bit`=0, `tx_valid`=0. Count GAP `tx_en` strobes, then go to IDLE.
- `tx_en` low in any state: all outputs hold; no advance.
- `tx_en` is ignored in IDLE.
- `load_valid` while not ready is ignored. No queueing; `load_data` and `load_len` are don't-care outside acceptance.
- `busy` = (state != IDLE). `load_ready` = !busy.
- Bit index and gap counters are sized so they never wrap within a frame. The len=WIDTH boundary must send all WIDTH bits.

## Timing
- Reset values: `tx_bit`=0, `tx_valid`=0, `done`=0, `busy`=0, `load_ready`=1. State is IDLE.
- Loads presented while `reset` is high are ignored.
- Reset mid-frame: outputs clear asynchronously and the frame is abandoned. `done` does not pulse.
- Latency: acceptance at edge N puts the first header bit on `tx_bit` after edge N, valid in cycle N+1.
- With `tx_en` held high, a frame occupies HDR_W+len cycles of `tx_valid`. `done` is high in cycle N+1+HDR_W+len. `load_ready` rises GAP cycles after `done`.
- Back-to-back: a load may be accepted in the first cycle `load_ready`=1.
- Each bit is stable for at least one cycle and changes only on a `tx_en` edge.

## Test plan
- Defaults, `tx_en`=1, load 32'hA5 with len 8 at cycle 0. Required: `tx_bit` = 1,1,1,0,1,0,0,1,0,1 in cycles 1–10, `tx_valid`=1 throughout. `done` in cycle 11; `load_ready`=1 at cycle 13.
- len=0: header 1,1 only. `done` in cycle 3; no DATA-state cycles.
- len=32, data 32'h8000_0001, `tx_en`=1. Required: 1,1,1, then 30 zeros, then 1. `done` at cycle 35. Also load len=40: clamped to 32, identical output.
- `tx_en` toggling 1,0,0,1,… on the 32'hA5 frame. Required: each bit held while `tx_en`=0; sequence unchanged; `done` only after the 10th strobe.
- Assert `reset` in the 4th payload bit. Required: `tx_valid`, `tx_bit`, `busy` drop the same cycle (async); no `done` pulse. After release, a new load of 8'h03 len 2 yields 1,1,1,1.
- Loopback into the sequence detector with len=1 data 0. Required: detector `output_signal` rises on the header "11". Gap zeros return the detector to S0 before the next frame.
